// File: rtl/demosaic_mem_arbiter.sv
// demosaic_mem_arbiter: shares the R/G/B colour SRAMs between the demosaic
// engine (E, priority) and the host port (H, low priority, bounded wait).
// Owns all SRAM control pins and steers read data back to the requester
// that issued the read.
module demosaic_mem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                e_req,
    input  logic [2:0]          e_we,
    input  logic [ADDR_W-1:0]   e_addr,
    input  logic [3*DATA_W-1:0] e_wdata,
    output logic                e_gnt,
    output logic                e_rvalid,
    input  logic                h_req,
    input  logic [2:0]          h_we,
    input  logic [ADDR_W-1:0]   h_addr,
    input  logic [3*DATA_W-1:0] h_wdata,
    output logic                h_gnt,
    output logic                h_rvalid,
    output logic [3*DATA_W-1:0] rdata,
    output logic                wr_r,
    output logic                wr_g,
    output logic                wr_b,
    output logic [ADDR_W-1:0]   addr_r,
    output logic [ADDR_W-1:0]   addr_g,
    output logic [ADDR_W-1:0]   addr_b,
    output logic [DATA_W-1:0]   wdata_r,
    output logic [DATA_W-1:0]   wdata_g,
    output logic [DATA_W-1:0]   wdata_b,
    input  logic [DATA_W-1:0]   rdata_r,
    input  logic [DATA_W-1:0]   rdata_g,
    input  logic [DATA_W-1:0]   rdata_b,
    output logic                starved
);

    // Handshake: a requester holds req with its fields stable; the transfer
    // happens in a cycle where req=1 and gnt=1 (gnt is combinational from req
    // and the wait counter). req may drop at any time; nothing is accepted
    // without gnt. At most one gnt is high per cycle.

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0]          r_wait_cnt;
    logic                r_starved;
    logic [2:0]          r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [3*DATA_W-1:0] r_wdata;
    logic                r_tag1_v;
    logic                r_tag1_id;   // 0 = engine, 1 = host
    logic                r_tag2_v;
    logic                r_tag2_id;

    logic                w_force_h;
    logic                w_e_gnt;
    logic                w_h_gnt;
    logic [2:0]          w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [3*DATA_W-1:0] w_sel_wdata;
    logic                w_rd_issue;

    // Arbitration: E by default; H when E is idle or H has waited MAX_WAIT.
    always_comb begin
        w_force_h   = h_req && e_req && (r_wait_cnt == WAIT_MAX);
        w_e_gnt     = e_req && !w_force_h;
        w_h_gnt     = h_req && (!e_req || w_force_h);
        w_sel_we    = w_h_gnt ? h_we    : e_we;
        w_sel_addr  = w_h_gnt ? h_addr  : e_addr;
        w_sel_wdata = w_h_gnt ? h_wdata : e_wdata;
        w_rd_issue  = (w_e_gnt || w_h_gnt) && (w_sel_we == 3'b000);
    end

    // Host wait counter and the sticky starvation flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= 4'd0;
            r_starved  <= 1'b0;
        end else begin
            if (!h_req || w_h_gnt)
                r_wait_cnt <= 4'd0;
            else if (r_wait_cnt < WAIT_MAX)
                r_wait_cnt <= r_wait_cnt + 4'd1;
            if (w_force_h)
                r_starved <= 1'b1;
        end
    end

    // Command stage: register the winner onto all three SRAM ports.
    // Address and write data hold when idle; only the strobes clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= 3'b000;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_e_gnt || w_h_gnt) begin
            r_wr    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end else begin
            r_wr    <= 3'b000;
        end
    end

    // Read tag pipe: stage 1 tracks the SRAM command, stage 2 the SRAM output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag1_v  <= 1'b0;
            r_tag1_id <= 1'b0;
            r_tag2_v  <= 1'b0;
            r_tag2_id <= 1'b0;
        end else begin
            r_tag1_v  <= w_rd_issue;
            r_tag1_id <= w_h_gnt;
            r_tag2_v  <= r_tag1_v;
            r_tag2_id <= r_tag1_id;
        end
    end

    assign e_gnt    = w_e_gnt;
    assign h_gnt    = w_h_gnt;
    assign e_rvalid = r_tag2_v && !r_tag2_id;
    assign h_rvalid = r_tag2_v && r_tag2_id;
    assign rdata    = {rdata_r, rdata_g, rdata_b};
    assign wr_r     = r_wr[2];
    assign wr_g     = r_wr[1];
    assign wr_b     = r_wr[0];
    assign addr_r   = r_addr;
    assign addr_g   = r_addr;
    assign addr_b   = r_addr;
    assign wdata_r  = r_wdata[2*DATA_W +: DATA_W];
    assign wdata_g  = r_wdata[DATA_W +: DATA_W];
    assign wdata_b  = r_wdata[0 +: DATA_W];
    assign starved  = r_starved;

endmodule

// File: tb/tb_demosaic_mem_arbiter.sv
// Bench for demosaic_mem_arbiter: behavioural SRAM, directed scenarios and
// randomized traffic checked against a transaction-level reference model.
module tb_demosaic_mem_arbiter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 8;
  localparam int MAX_WAIT = 8;
  localparam int DEPTH    = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        e_req = 1'b0, h_req = 1'b0;
  logic [2:0]  e_we = 3'b0, h_we = 3'b0;
  logic [13:0] e_addr = '0, h_addr = '0;
  logic [23:0] e_wdata = '0, h_wdata = '0;
  logic        e_gnt, h_gnt, e_rvalid, h_rvalid, starved;
  logic [23:0] rdata;
  logic        wr_r, wr_g, wr_b;
  logic [13:0] addr_r, addr_g, addr_b;
  logic [7:0]  wdata_r, wdata_g, wdata_b;
  logic [7:0]  rdata_r, rdata_g, rdata_b;

  demosaic_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid),
    .rdata(rdata),
    .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
    .addr_r(addr_r), .addr_g(addr_g), .addr_b(addr_b),
    .wdata_r(wdata_r), .wdata_g(wdata_g), .wdata_b(wdata_b),
    .rdata_r(rdata_r), .rdata_g(rdata_g), .rdata_b(rdata_b),
    .starved(starved)
  );

  // Power-on contents: address 0x0081 holds R=0x10, G=0x20, B=0x30.
  function automatic logic [7:0] init_val(input int ch, input logic [13:0] a);
    int t;
    t = int'(a) - 'h81;
    return 8'((t * 3 + (ch + 1) * 16) & 255);
  endfunction

  // ---------------- behavioural SRAMs (read-first, 1-cycle latency) ----------------
  logic [7:0]       sram_r [DEPTH];
  logic [7:0]       sram_g [DEPTH];
  logic [7:0]       sram_b [DEPTH];
  logic [DEPTH-1:0] wrote_r, wrote_g, wrote_b;

  always @(posedge clk) begin
    if (!reset_n) begin
      wrote_r <= '0;
      wrote_g <= '0;
      wrote_b <= '0;
    end else begin
      if (wr_r) begin sram_r[addr_r] <= wdata_r; wrote_r[addr_r] <= 1'b1; end
      if (wr_g) begin sram_g[addr_g] <= wdata_g; wrote_g[addr_g] <= 1'b1; end
      if (wr_b) begin sram_b[addr_b] <= wdata_b; wrote_b[addr_b] <= 1'b1; end
    end
    rdata_r <= (reset_n && wrote_r[addr_r]) ? sram_r[addr_r] : init_val(0, addr_r);
    rdata_g <= (reset_n && wrote_g[addr_g]) ? sram_g[addr_g] : init_val(1, addr_g);
    rdata_b <= (reset_n && wrote_b[addr_b]) ? sram_b[addr_b] : init_val(2, addr_b);
  end

  // ---------------- reference model ----------------
  logic [7:0]  m_r [DEPTH];
  logic [7:0]  m_g [DEPTH];
  logic [7:0]  m_b [DEPTH];
  int          m_wait;        // consecutive cycles H has been refused
  logic        m_starved;
  logic [2:0]  m_wr;
  logic [13:0] m_addr;
  logic [23:0] m_wdata;
  // Scoreboard entries {valid, is_host, data}, one per cycle.
  logic [25:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_r[i] = init_val(0, 14'(i));
      m_g[i] = init_val(1, 14'(i));
      m_b[i] = init_val(2, 14'(i));
    end
    m_wait = 0; m_starved = 1'b0; m_wr = 3'b0; m_addr = '0; m_wdata = '0;
    exp_q.delete();
    exp_q.push_back(26'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_e(input logic req, input logic [2:0] we, input logic [13:0] a, input logic [23:0] wd);
    e_req = req; e_we = we; e_addr = a; e_wdata = wd;
  endtask

  task automatic drive_h(input logic req, input logic [2:0] we, input logic [13:0] a, input logic [23:0] wd);
    h_req = req; h_we = we; h_addr = a; h_wdata = wd;
  endtask

  task automatic idle();
    drive_e(1'b0, 3'b0, e_addr, e_wdata);
    drive_h(1'b0, 3'b0, h_addr, h_wdata);
  endtask

  // Called just after a negedge with inputs driven; returns at the next negedge.
  task automatic cycle();
    logic        force_h, eg, hg;
    logic [2:0]  we;
    logic [13:0] a;
    logic [23:0] wd;
    logic [25:0] ent;
    #1;
    force_h = h_req && e_req && (m_wait >= MAX_WAIT);
    eg = e_req && !force_h;
    hg = h_req && (!e_req || force_h);
    chk("e_gnt", 32'(e_gnt), 32'(eg));
    chk("h_gnt", 32'(h_gnt), 32'(hg));
    ent = 26'd0;
    if (eg || hg) begin
      we = hg ? h_we : e_we;
      a  = hg ? h_addr : e_addr;
      wd = hg ? h_wdata : e_wdata;
      m_wr = we; m_addr = a; m_wdata = wd;
      if (we == 3'b000) begin
        ent = {1'b1, hg, m_r[a], m_g[a], m_b[a]};
      end else begin
        if (we[2]) m_r[a] = wd[23:16];
        if (we[1]) m_g[a] = wd[15:8];
        if (we[0]) m_b[a] = wd[7:0];
      end
    end else begin
      m_wr = 3'b000;
    end
    if (force_h) m_starved = 1'b1;
    if (!h_req || hg) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
    exp_q.push_back(ent);

    @(posedge clk); #1;
    ent = exp_q.pop_front();
    chk("wr",      32'({wr_r, wr_g, wr_b}), 32'(m_wr));
    chk("addr_r",  32'(addr_r), 32'(m_addr));
    chk("addr_g",  32'(addr_g), 32'(m_addr));
    chk("addr_b",  32'(addr_b), 32'(m_addr));
    chk("wdata",   32'({wdata_r, wdata_g, wdata_b}), 32'(m_wdata));
    chk("starved", 32'(starved), 32'(m_starved));
    chk("e_rvalid", 32'(e_rvalid), 32'(ent[25] && !ent[24]));
    chk("h_rvalid", 32'(h_rvalid), 32'(ent[25] && ent[24]));
    if (ent[25]) chk("rdata", 32'(rdata), 32'(ent[23:0]));
    @(negedge clk);
  endtask

  // Called just after a negedge; asserts reset asynchronously mid-cycle.
  task automatic apply_reset();
    idle();
    reset_n = 1'b0;
    #1;
    chk("rst_wr",      32'({wr_r, wr_g, wr_b}), 32'd0);
    chk("rst_addr",    32'({addr_r, addr_g, addr_b}), 32'd0);
    chk("rst_wdata",   32'({wdata_r, wdata_g, wdata_b}), 32'd0);
    chk("rst_rvalid",  32'({e_rvalid, h_rvalid}), 32'd0);
    chk("rst_starved", 32'(starved), 32'd0);
    drive_e(1'b1, 3'b0, 14'd0, 24'd0);
    drive_h(1'b1, 3'b0, 14'd0, 24'd0);
    #1;
    chk("rst_gnt", 32'({e_gnt, h_gnt}), 32'b10);
    idle();
    repeat (2) @(negedge clk);
    chk("rst_hold_rvalid", 32'({e_rvalid, h_rvalid}), 32'd0);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic random_cycle();
    logic [2:0] we;
    we = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
    drive_e($urandom_range(0, 9) < 6, we,
            ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 7)),
            24'($urandom));
    we = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
    drive_h($urandom_range(0, 1) == 1, we,
            ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 7)),
            24'($urandom));
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    @(negedge clk);
    apply_reset();

    // Engine-only read of the preloaded location.
    drive_e(1'b1, 3'b000, 14'h0081, 24'd0); cycle();
    idle(); cycle(); cycle();

    // Channel-masked write then read back.
    drive_e(1'b1, 3'b100, 14'd5, 24'hAABBCC); cycle();
    idle(); cycle();
    drive_e(1'b1, 3'b000, 14'd5, 24'd0); cycle();
    idle(); cycle(); cycle();

    // Both requesting continuously: forced host grant on the 9th cycle.
    for (int i = 0; i < 20; i++) begin
      drive_e(1'b1, 3'b000, 14'(16 + i), 24'd0);
      drive_h(1'b1, 3'b000, 14'(100 + i), 24'd0);
      cycle();
    end
    idle(); cycle(); cycle();

    // Host alone on an idle engine: immediate grant, no starvation.
    apply_reset();
    drive_h(1'b1, 3'b000, 14'h3FFF, 24'd0); cycle();
    idle(); cycle(); cycle();

    // Interleaved back-to-back with read-after-write.
    drive_e(1'b1, 3'b000, 14'h0010, 24'd0); cycle();
    drive_e(1'b0, 3'b000, 14'h0010, 24'd0);
    drive_h(1'b1, 3'b000, 14'h0020, 24'd0); cycle();
    drive_h(1'b0, 3'b000, 14'h0020, 24'd0);
    drive_e(1'b1, 3'b111, 14'h0010, 24'h123456); cycle();
    drive_e(1'b1, 3'b000, 14'h0010, 24'd0); cycle();
    idle(); cycle(); cycle(); cycle();

    // Reset one cycle after an engine read grant; grant right after release.
    drive_e(1'b1, 3'b000, 14'h0081, 24'd0); cycle();
    apply_reset();
    drive_e(1'b1, 3'b000, 14'h0042, 24'd0); cycle();
    idle(); cycle(); cycle(); cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) apply_reset();
      random_cycle();
    end
    idle(); cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
